imem_boot_ctl: RTL and testbench

Boot controller for the single-cycle core.
- Holds the core in reset while it accepts a program image word-by-word over a valid/ready stream.
- Writes each word into instruction memory through the imem write port.
- Releases the core from reset a fixed number of cycles after the last write.
- Sits beside the top-level core: drives the core's `reset`, `wr_en_imem` and `wr_instr_imem`, and supplies the imem write address.
- Supports re-boot from the running state.

---
 rtl/imem_boot_ctl.sv | 121 ++++++++++++
 tb/tb_imem_boot_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctl.sv
// Boot controller: holds the core in reset, streams a program image into imem,
// then releases the core a fixed number of cycles after the final write.
module imem_boot_ctl #(
   parameter int unsigned NUM_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned HOLD_CYC  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_boot_i,
   input  logic [15:0] len_boot_i,
   input  logic        in_valid_boot_i,
   input  logic [31:0] in_data_boot_i,
   output logic        in_ready_boot_o,
   output logic        wr_en_imem_o,
   output logic [31:0] addr_imem_o,
   output logic [31:0] wr_instr_imem_o,
   output logic        core_reset_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int unsigned CNT_W  = $clog2(NUM_WORDS + 1);
   localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, len_q;
   logic [HOLD_W-1:0]   hold_q;
   logic                ready_q, ready_d;
   logic                wr_en_q, wr_en_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         data_q, data_d;
   logic                core_rst_q, core_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic len_ok, xfer, last_xfer, hold_done, accept;

   assign len_ok    = (len_boot_i != 16'd0) && (32'(len_boot_i) <= NUM_WORDS);
   assign xfer      = in_valid_boot_i && ready_q;
   assign last_xfer = xfer && (cnt_q == len_q - CNT_W'(1));
   assign hold_done = (hold_q == HOLD_W'(HOLD_CYC - 1));
   assign accept    = (state_d == S_LOAD) && (state_q != S_LOAD);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= BASE_ADDR;
         data_q     <= 32'd0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         wr_en_q    <= wr_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         len_q  <= '0;
         hold_q <= '0;
      end else begin
         if (accept) begin
            cnt_q <= '0;
            len_q <= len_boot_i[CNT_W-1:0];
         end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         hold_q <= (state_q == S_HOLD) ? hold_q + HOLD_W'(1) : '0;
      end
   end

   // Start is only honoured outside LOAD/HOLD; invalid lengths land in ERR
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERR: if (start_boot_i) state_d = len_ok ? S_LOAD : S_ERR;
         S_LOAD:               if (last_xfer) state_d = S_HOLD;
         S_HOLD:               if (hold_done) state_d = S_RUN;
         default:              state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_d    = (state_d == S_LOAD);
      core_rst_d = (state_d != S_RUN);
      busy_d     = (state_d == S_LOAD) || (state_d == S_HOLD);
      done_d     = (state_d == S_RUN);
      err_d      = (state_d == S_ERR);
      wr_en_d    = xfer;
      addr_d     = xfer ? BASE_ADDR + (32'(cnt_q) << 2) : addr_q;
      data_d     = xfer ? in_data_boot_i : data_q;
   end

   assign in_ready_boot_o = ready_q;
   assign wr_en_imem_o    = wr_en_q;
   assign addr_imem_o     = addr_q;
   assign wr_instr_imem_o = data_q;
   assign core_reset_o    = core_rst_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_imem_boot_ctl.sv
// Directed bench for imem_boot_ctl with hand-computed expectations
// (NUM_WORDS=256, BASE_ADDR=0, HOLD_CYC=2).
module tb_imem_boot_ctl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_boot_i;
   logic [15:0] len_boot_i;
   logic        in_valid_boot_i;
   logic [31:0] in_data_boot_i;
   logic        in_ready_boot_o;
   logic        wr_en_imem_o;
   logic [31:0] addr_imem_o;
   logic [31:0] wr_instr_imem_o;
   logic        core_reset_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int n_cmp = 0;
   int n_bad = 0;

   imem_boot_ctl #(
      .NUM_WORDS(256),
      .BASE_ADDR(32'h0000_0000),
      .HOLD_CYC (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start_boot_i    (start_boot_i),
      .len_boot_i      (len_boot_i),
      .in_valid_boot_i (in_valid_boot_i),
      .in_data_boot_i  (in_data_boot_i),
      .in_ready_boot_o (in_ready_boot_o),
      .wr_en_imem_o    (wr_en_imem_o),
      .addr_imem_o     (addr_imem_o),
      .wr_instr_imem_o (wr_instr_imem_o),
      .core_reset_o    (core_reset_o),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_write(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_wr_en"}, 32'(wr_en_imem_o), 32'd1);
      chk({tag, "_addr"}, addr_imem_o, a);
      chk({tag, "_data"}, wr_instr_imem_o, d);
   endtask

   initial begin
      reset = 1'b1; start_boot_i = 1'b0; len_boot_i = 16'd0;
      in_valid_boot_i = 1'b0; in_data_boot_i = 32'd0;
      tick(); tick();
      reset = 1'b0;

      // reset values
      chk("rst_core_reset", 32'(core_reset_o), 32'd1);
      chk("rst_ready", 32'(in_ready_boot_o), 32'd0);
      chk("rst_wr_en", 32'(wr_en_imem_o), 32'd0);
      chk("rst_addr", addr_imem_o, 32'h0);
      chk("rst_data", wr_instr_imem_o, 32'h0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);

      // idle 5 cycles with a word offered that must not be consumed
      in_valid_boot_i = 1'b1; in_data_boot_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_core_reset", 32'(core_reset_o), 32'd1);
         chk("idle_done", 32'(done_o), 32'd0);
         chk("idle_wr_en", 32'(wr_en_imem_o), 32'd0);
         chk("idle_ready", 32'(in_ready_boot_o), 32'd0);
      end
      in_valid_boot_i = 1'b0;

      // len=4 continuous
      start_boot_i = 1'b1; len_boot_i = 16'd4;
      tick();
      start_boot_i = 1'b0;
      chk("b4_ready", 32'(in_ready_boot_o), 32'd1);
      chk("b4_busy", 32'(busy_o), 32'd1);
      chk("b4_wr_en0", 32'(wr_en_imem_o), 32'd0);
      in_valid_boot_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data_boot_i = 32'hA0 + 32'(i);
         tick();
         chk_write("b4", 32'(4 * i), 32'hA0 + 32'(i));
         chk("b4_ready_i", 32'(in_ready_boot_o), (i < 3) ? 32'd1 : 32'd0);
         chk("b4_core_reset_i", 32'(core_reset_o), 32'd1);
      end
      in_valid_boot_i = 1'b0;
      tick();
      chk("b4_hold_wr_en", 32'(wr_en_imem_o), 32'd0);
      chk("b4_hold_core_reset", 32'(core_reset_o), 32'd1);
      chk("b4_hold_busy", 32'(busy_o), 32'd1);
      chk("b4_hold_done", 32'(done_o), 32'd0);
      tick();
      chk("b4_run_core_reset", 32'(core_reset_o), 32'd0);
      chk("b4_run_done", 32'(done_o), 32'd1);
      chk("b4_run_busy", 32'(busy_o), 32'd0);

      // len=3 from RUN with valid 1,0,1,0,1
      start_boot_i = 1'b1; len_boot_i = 16'd3;
      tick();
      start_boot_i = 1'b0;
      chk("b3_core_reset", 32'(core_reset_o), 32'd1);
      chk("b3_done", 32'(done_o), 32'd0);
      chk("b3_ready", 32'(in_ready_boot_o), 32'd1);
      for (int k = 0; k < 5; k++) begin
         in_valid_boot_i = (k % 2 == 0);
         in_data_boot_i  = 32'hB0 + 32'(k / 2);
         tick();
         if (k % 2 == 0) begin
            chk_write("b3", 32'(4 * (k / 2)), 32'hB0 + 32'(k / 2));
         end else begin
            chk("b3_gap_wr_en", 32'(wr_en_imem_o), 32'd0);
            chk("b3_gap_addr_hold", addr_imem_o, 32'(4 * (k / 2)));
            chk("b3_gap_ready", 32'(in_ready_boot_o), 32'd1);
         end
      end
      chk("b3_last_ready", 32'(in_ready_boot_o), 32'd0);
      in_valid_boot_i = 1'b0;
      tick();
      chk("b3_hold_core_reset", 32'(core_reset_o), 32'd1);
      tick();
      chk("b3_run_core_reset", 32'(core_reset_o), 32'd0);
      chk("b3_run_done", 32'(done_o), 32'd1);

      // invalid lengths
      start_boot_i = 1'b1; len_boot_i = 16'd0;
      tick();
      chk("e0_err", 32'(err_o), 32'd1);
      chk("e0_core_reset", 32'(core_reset_o), 32'd1);
      chk("e0_done", 32'(done_o), 32'd0);
      chk("e0_wr_en", 32'(wr_en_imem_o), 32'd0);
      len_boot_i = 16'd257;
      tick();
      chk("e257_err", 32'(err_o), 32'd1);
      chk("e257_wr_en", 32'(wr_en_imem_o), 32'd0);
      chk("e257_ready", 32'(in_ready_boot_o), 32'd0);
      len_boot_i = 16'd1;
      tick();
      start_boot_i = 1'b0;
      chk("e1_err_clr", 32'(err_o), 32'd0);
      chk("e1_ready", 32'(in_ready_boot_o), 32'd1);
      in_valid_boot_i = 1'b1; in_data_boot_i = 32'hC0;
      tick();
      in_valid_boot_i = 1'b0;
      chk_write("e1", 32'h0, 32'hC0);
      chk("e1_ready_drop", 32'(in_ready_boot_o), 32'd0);
      tick(); tick();
      chk("e1_run_core_reset", 32'(core_reset_o), 32'd0);
      chk("e1_run_done", 32'(done_o), 32'd1);

      // len=NUM_WORDS is accepted
      start_boot_i = 1'b1; len_boot_i = 16'd256;
      tick();
      start_boot_i = 1'b0;
      chk("max_ready", 32'(in_ready_boot_o), 32'd1);
      chk("max_err", 32'(err_o), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // reset after 2nd of 5 transfers
      start_boot_i = 1'b1; len_boot_i = 16'd5;
      tick();
      start_boot_i = 1'b0;
      in_valid_boot_i = 1'b1;
      in_data_boot_i = 32'hD0;
      tick();
      chk_write("r1", 32'h0, 32'hD0);
      in_data_boot_i = 32'hD1;
      tick();
      chk_write("r2", 32'h4, 32'hD1);
      reset = 1'b1; in_data_boot_i = 32'hD2;
      tick();
      reset = 1'b0;
      chk("r_wr_en", 32'(wr_en_imem_o), 32'd0);
      chk("r_ready", 32'(in_ready_boot_o), 32'd0);
      chk("r_core_reset", 32'(core_reset_o), 32'd1);
      chk("r_addr", addr_imem_o, 32'h0);
      chk("r_data", wr_instr_imem_o, 32'h0);
      chk("r_busy", 32'(busy_o), 32'd0);
      tick();
      chk("r_idle_wr_en", 32'(wr_en_imem_o), 32'd0);
      in_valid_boot_i = 1'b0;
      start_boot_i = 1'b1; len_boot_i = 16'd2;
      tick();
      start_boot_i = 1'b0;
      in_valid_boot_i = 1'b1; in_data_boot_i = 32'hE0;
      tick();
      chk_write("r_new0", 32'h0, 32'hE0);
      in_data_boot_i = 32'hE1;
      tick();
      in_valid_boot_i = 1'b0;
      chk_write("r_new1", 32'h4, 32'hE1);
      tick(); tick();
      chk("r_new_core_reset", 32'(core_reset_o), 32'd0);
      chk("r_new_done", 32'(done_o), 32'd1);

      // re-boot from RUN, with a stray invalid start during LOAD
      start_boot_i = 1'b1; len_boot_i = 16'd2;
      tick();
      chk("rb_core_reset", 32'(core_reset_o), 32'd1);
      chk("rb_done", 32'(done_o), 32'd0);
      chk("rb_busy", 32'(busy_o), 32'd1);
      len_boot_i = 16'd0;
      in_valid_boot_i = 1'b1; in_data_boot_i = 32'hF0;
      tick();
      start_boot_i = 1'b0;
      chk_write("rb0", 32'h0, 32'hF0);
      chk("rb_err_ignored", 32'(err_o), 32'd0);
      in_data_boot_i = 32'hF1;
      tick();
      in_valid_boot_i = 1'b0;
      chk_write("rb1", 32'h4, 32'hF1);
      tick();
      chk("rb_hold_wr_en", 32'(wr_en_imem_o), 32'd0);
      chk("rb_hold_core_reset", 32'(core_reset_o), 32'd1);
      tick();
      chk("rb_run_core_reset", 32'(core_reset_o), 32'd0);
      chk("rb_run_done", 32'(done_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
